// File: rtl/event_flag_sched.sv
// Bank of N sticky set/reset event flags plus a round-robin scheduler that
// hands one pending, unmasked flag at a time to a single consumer via req/ack.
module event_flag_sched #(
  parameter int N   = 8,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           en,
  input  logic [N-1:0]   ev_set,
  input  logic [N-1:0]   sw_clr,
  input  logic [N-1:0]   mask,
  output logic [N-1:0]   pending,
  output logic           req,
  output logic [IDW-1:0] req_id,
  input  logic           ack,
  output logic           busy
);

  // Handshake: req rises with a registered req_id and both hold until the
  // consumer pulses ack; ack is honoured only while req=1 (WAIT), and req
  // always drops for at least one cycle (GAP) before the next grant.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [N-1:0]   elig;
  logic [N-1:0]   ack_clr;
  logic [2*N-1:0] rot;
  logic           found;
  logic [IDW-1:0] sel;
  logic [IDW:0]   sum;
  logic [IDW-1:0] nxt_ptr;

  assign elig = pending & ~mask;

  always_comb begin
    ack_clr = '0;
    if (state == WAIT && ack) ack_clr[req_id] = 1'b1;
  end

  // Rotating the doubled vector puts ptr at bit 0, so the lowest set bit
  // of the low half is the first eligible flag searching upward with wrap.
  assign rot = {elig, elig} >> ptr;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    sum   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (IDW+1)'(k);
        if (sum >= (IDW+1)'(N)) sum = sum - (IDW+1)'(N);
        sel   = sum[IDW-1:0];
      end
    end
  end

  assign nxt_ptr = (req_id == IDW'(N-1)) ? '0 : req_id + 1'b1;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pending <= '0;
      state   <= IDLE;
      req     <= 1'b0;
      req_id  <= '0;
      busy    <= 1'b0;
      ptr     <= '0;
    end else begin
      // Set wins over both software clear and the ack clear.
      if (en) pending <= ev_set | (pending & ~sw_clr & ~ack_clr);
      case (state)
        IDLE: begin
          if (found) begin
            req_id <= sel;
            state  <= WAIT;
            req    <= 1'b1;
            busy   <= 1'b1;
          end
        end
        WAIT: begin
          if (ack) begin
            ptr   <= nxt_ptr;
            state <= GAP;
            req   <= 1'b0;
          end
        end
        GAP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
